// File: rtl/hub75_fb_writer.sv
// hub75_fb_writer: write side of a double-buffered HUB75 framebuffer.
// Takes a raster-order RGB222 pixel stream (valid/ready + start-of-frame),
// writes each pixel into the top- or bottom-half bank of the back page and
// swaps pages on the scanner's frame boundary once a full frame is written.
// Optional build macro: FB_WRITER_RESYNC_EN (s_sof during a frame restarts it).
module hub75_fb_writer #(
  parameter int unsigned COLS  = 64,
  parameter int unsigned ROWS  = 32,
  parameter int unsigned PIX_W = 6
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [PIX_W-1:0]                       s_data,
  input  logic                                   s_valid,
  input  logic                                   s_sof,
  output logic                                   s_ready,
  input  logic                                   disp_vsync,
  output logic                                   wr_en_top,
  output logic                                   wr_en_bot,
  output logic [$clog2(ROWS)+$clog2(COLS)-1:0]   wr_addr,
  output logic [PIX_W-1:0]                       wr_data,
  output logic                                   front_page,
  output logic                                   frame_done,
  output logic                                   sof_err
);

  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned RW = $clog2(ROWS);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    WAIT_SWAP = 2'd2
  } state_t;

  state_t           r_state, w_state_nx;
  logic [CW-1:0]    r_col, w_col_nx, w_wcol;
  logic [RW-1:0]    r_row, w_row_nx, w_wrow;
  logic             w_acc, w_wr, w_err, w_swap;

  assign s_ready = (r_state != WAIT_SWAP) && !rst;
  assign w_acc   = s_valid && s_ready;

  // Next-state, next-counter and write-target decode.
  always_comb begin
    w_state_nx = r_state;
    w_col_nx   = r_col;
    w_row_nx   = r_row;
    w_wcol     = r_col;
    w_wrow     = r_row;
    w_wr       = 1'b0;
    w_err      = 1'b0;
    w_swap     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_acc && s_sof) begin
          w_wr       = 1'b1;
          w_wcol     = '0;
          w_wrow     = '0;
          w_col_nx   = COL_ONE;
          w_row_nx   = '0;
          w_state_nx = WRITE;
        end
      end
      WRITE: begin
        if (w_acc) begin
          w_wr  = 1'b1;
          w_err = s_sof;
`ifdef FB_WRITER_RESYNC_EN
          if (s_sof) begin
            w_wcol   = '0;
            w_wrow   = '0;
            w_col_nx = COL_ONE;
            w_row_nx = '0;
          end else
`endif
          if (r_col == COL_LAST) begin
            w_col_nx = '0;
            if (r_row == ROW_LAST) begin
              w_row_nx   = '0;
              w_state_nx = WAIT_SWAP;
            end else begin
              w_row_nx = r_row + ROW_ONE;
            end
          end else begin
            w_col_nx = r_col + COL_ONE;
          end
        end
      end
      WAIT_SWAP: begin
        if (disp_vsync) begin
          w_swap     = 1'b1;
          w_state_nx = IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // State, counters, page select and registered write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_col      <= '0;
      r_row      <= '0;
      wr_en_top  <= 1'b0;
      wr_en_bot  <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      front_page <= 1'b0;
      frame_done <= 1'b0;
      sof_err    <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_col      <= w_col_nx;
      r_row      <= w_row_nx;
      wr_en_top  <= w_wr && !w_wrow[RW-1];
      wr_en_bot  <= w_wr && w_wrow[RW-1];
      frame_done <= w_swap;
      sof_err    <= w_err;
      if (w_swap) front_page <= ~front_page;
      if (w_wr) begin
        wr_addr <= {~front_page, w_wrow[RW-2:0], w_wcol};
        wr_data <= s_data;
      end
    end
  end

endmodule

// File: tb/tb_hub75_fb_writer.sv
// Directed self-checking bench for hub75_fb_writer (default 64x32 build).
module tb_hub75_fb_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_sof = 1'b0;
  logic        s_ready;
  logic        disp_vsync = 1'b0;
  logic        wr_en_top, wr_en_bot;
  logic [10:0] wr_addr;
  logic [5:0]  wr_data;
  logic        front_page, frame_done, sof_err;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned nwr   = 0;

  hub75_fb_writer #(.COLS(64), .ROWS(32), .PIX_W(6)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_sof(s_sof),
    .s_ready(s_ready), .disp_vsync(disp_vsync), .wr_en_top(wr_en_top),
    .wr_en_bot(wr_en_bot), .wr_addr(wr_addr), .wr_data(wr_data),
    .front_page(front_page), .frame_done(frame_done), .sof_err(sof_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one beat for one clock; outputs of that beat are visible on return.
  task automatic send(input logic [5:0] d, input logic sof);
    s_data  = d;
    s_sof   = sof;
    s_valid = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", s_ready, 0);
    chk("rst_wren", {wr_en_top, wr_en_bot}, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 0);
    chk("rst_front", front_page, 0);
    chk("rst_flags", {frame_done, sof_err}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", s_ready, 1);

    // Full frame, with vsync mid-frame and on the final-beat cycle
    for (int i = 0; i < 2048; i++) begin
      disp_vsync = (i == 500 || i == 2047);
      send(6'(i), i == 0);
      disp_vsync = 1'b0;
      if (wr_en_top || wr_en_bot) nwr++;
      if (i == 0) begin
        chk("b0_addr", wr_addr, 11'h400);
        chk("b0_en", {wr_en_top, wr_en_bot}, 2'b10);
        chk("b0_data", wr_data, 0);
      end
      if (i == 1023) begin
        chk("b1023_addr", wr_addr, 11'h7FF);
        chk("b1023_en", {wr_en_top, wr_en_bot}, 2'b10);
        chk("b1023_data", wr_data, 6'h3F);
      end
      if (i == 1024) begin
        chk("b1024_addr", wr_addr, 11'h400);
        chk("b1024_en", {wr_en_top, wr_en_bot}, 2'b01);
      end
      if (i == 2047) begin
        chk("b2047_addr", wr_addr, 11'h7FF);
        chk("b2047_en", {wr_en_top, wr_en_bot}, 2'b01);
        chk("b2047_ready", s_ready, 0);
        chk("b2047_front", front_page, 0);
        chk("b2047_done", frame_done, 0);
      end
    end
    chk("frame1_writes", nwr, 2048);

    // Beat offered during WAIT_SWAP is not taken; page stays put
    send(6'h2A, 1'b1);
    chk("wait_no_write", {wr_en_top, wr_en_bot}, 0);
    chk("wait_ready", s_ready, 0);
    chk("wait_front", front_page, 0);

    // Swap on vsync
    disp_vsync = 1'b1;
    @(posedge clk);
    #1;
    disp_vsync = 1'b0;
    chk("swap_front", front_page, 1);
    chk("swap_done", frame_done, 1);
    chk("swap_ready", s_ready, 1);
    @(posedge clk);
    #1;
    chk("swap_done_pulse", frame_done, 0);
    chk("swap_front_hold", front_page, 1);

    // Next frame on page 0; sof at beat 100
    send(6'h15, 1'b1);
    chk("f2_addr", wr_addr, 11'h000);
    chk("f2_en", {wr_en_top, wr_en_bot}, 2'b10);
    chk("f2_data", wr_data, 6'h15);
    for (int i = 1; i < 100; i++) send(6'(i), 1'b0);
    chk("b99_err", sof_err, 0);
    send(6'h33, 1'b1);
    chk("b100_err", sof_err, 1);
    chk("b100_data", wr_data, 6'h33);
`ifdef FB_WRITER_RESYNC_EN
    chk("b100_addr", wr_addr, 11'h000);
`else
    chk("b100_addr", wr_addr, 11'h064);
`endif
    send(6'h01, 1'b0);
    chk("b101_err", sof_err, 0);
`ifdef FB_WRITER_RESYNC_EN
    chk("b101_addr", wr_addr, 11'h001);
`else
    chk("b101_addr", wr_addr, 11'h065);
`endif

    // Mid-frame reset at beat 500
    for (int i = 102; i < 500; i++) send(6'(i), 1'b0);
    s_data  = 6'h3C;
    s_valid = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    chk("arst_ready", s_ready, 0);
    chk("arst_wren", {wr_en_top, wr_en_bot}, 0);
    chk("arst_addr", wr_addr, 0);
    chk("arst_data", wr_data, 0);
    chk("arst_front", front_page, 0);
    s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // IDLE: non-sof beats dropped, sof beat starts a frame on page 1
    for (int i = 0; i < 5; i++) begin
      send(6'(i + 7), 1'b0);
      chk("idle_drop", {wr_en_top, wr_en_bot}, 0);
    end
    send(6'h2D, 1'b1);
    chk("idle_sof_addr", wr_addr, 11'h400);
    chk("idle_sof_en", {wr_en_top, wr_en_bot}, 2'b10);
    chk("idle_sof_data", wr_data, 6'h2D);
    chk("idle_sof_err", sof_err, 0);
    @(posedge clk);
    #1;
    chk("idle_sof_pulse", {wr_en_top, wr_en_bot}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
